// File: rtl/vermibus_arbiter.sv
// Two-master, one-slave Vermibus arbiter: round-robin grant held until slave
// completion, with an optional bounded timeout that force-completes hung transfers.
module vermibus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_address,
    input  logic [3:0]  m0_wstrobe,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_address,
    input  logic [3:0]  m1_wstrobe,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_address,
    output logic [3:0]  s_wstrobe,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        abort_m_q, abort_m_d;
    logic [15:0] cnt_q, cnt_d;

    logic        in_grant, sel_m, sel_valid, done;
    logic [15:0] cnt_inc;

    assign in_grant  = (state_q == GRANT0) || (state_q == GRANT1);
    assign sel_m     = (state_q == GRANT1);
    assign sel_valid = sel_m ? m1_valid : m0_valid;
    assign done      = in_grant && sel_valid && s_ready;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        abort_m_d    = abort_m_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_valid && m1_valid)
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (m0_valid)
                    state_d = GRANT0;
                else if (m1_valid)
                    state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                // A master dropping valid mid-grant is a protocol violation:
                // abandon quietly without touching fairness state.
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (done) begin
                    state_d      = IDLE;
                    last_grant_d = sel_m;
                end else begin
                    cnt_d = cnt_inc;
                    if (TO_EN && cnt_inc == TO_LIM) begin
                        state_d   = ABORT;
                        abort_m_d = sel_m;
                    end
                end
            end
            ABORT: begin
                state_d      = IDLE;
                last_grant_d = abort_m_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            abort_m_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            abort_m_q    <= abort_m_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        s_valid   = 1'b0;
        s_address = '0;
        s_wstrobe = '0;
        s_wdata   = '0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        timeout   = 1'b0;
        if (in_grant) begin
            s_valid   = sel_valid;
            s_address = sel_m ? m1_address : m0_address;
            s_wstrobe = sel_m ? m1_wstrobe : m0_wstrobe;
            s_wdata   = sel_m ? m1_wdata   : m0_wdata;
            if (sel_m) begin
                m1_ready = done;
                m1_rdata = s_rdata;
            end else begin
                m0_ready = done;
                m0_rdata = s_rdata;
            end
        end else if (state_q == ABORT) begin
            timeout  = 1'b1;
            m0_ready = !abort_m_q;
            m1_ready = abort_m_q;
        end
    end
endmodule
